// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: active-high glyphs (bit 6 = a),
// default slot length and the anode one-hot helper.
package seg7_pkg;

  localparam int DIV_DEFAULT = 100000;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // Bit 'pos' of the one-hot anode vector for the digit currently selected.
  function automatic logic onehot_bit(input int unsigned sel, input int unsigned pos);
    return sel == pos;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-high a..g glyph; polarity is applied by the caller.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_0;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      default: glyph_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with frame-atomic value snapshot,
// decimal points, leading-zero blanking, PWM brightness and selectable polarity.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NDIGIT     = 8,
  parameter int DIV        = DIV_DEFAULT,
  parameter int PWM_BITS   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic [4*NDIGIT-1:0]   w_din,
  input  logic [NDIGIT-1:0]     w_dp,
  input  logic                  w_blank_lz,
  input  logic [PWM_BITS-1:0]   w_bright,
  output logic [6:0]            r_sg,
  output logic                  r_dp,
  output logic [NDIGIT-1:0]     r_an,
  output logic                  r_frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NDIGIT - 1);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [6:0]        SG_OFF = {7{POL}};
  localparam logic [NDIGIT-1:0] AN_OFF = {NDIGIT{POL}};

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        digit_q, digit_d;
  logic [PWM_BITS-1:0]  pwm_q;
  logic [4*NDIGIT-1:0]  din_shadow_q, din_shadow_d;
  logic [NDIGIT-1:0]    dp_shadow_q, dp_shadow_d;
  logic                 frame_q, frame_d;
  logic [6:0]           sg_q, sg_d;
  logic                 dp_q, dp_d;
  logic [NDIGIT-1:0]    an_q, an_d;

  logic                 tick, last_digit, an_on;
  logic [NDIGIT-1:0]    an_onehot, lz_blank;
  logic                 zero_run;
  logic [3:0]           nib_sel;
  logic                 dp_sel, blank_sel;
  logic [6:0]           glyph;

  assign tick       = (cnt_q == CNT_LAST);
  assign last_digit = (digit_q == DIGIT_LAST);

  // Shadows reload only on the frame wrap so a frame never mixes old and new values.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    digit_d      = digit_q;
    din_shadow_d = din_shadow_q;
    dp_shadow_d  = dp_shadow_q;
    frame_d      = 1'b0;
    if (tick) begin
      cnt_d = '0;
      if (last_digit) begin
        digit_d      = '0;
        din_shadow_d = w_din;
        dp_shadow_d  = w_dp;
        frame_d      = 1'b1;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NDIGIT; gi++) begin : g_anode
    assign an_onehot[gi] = onehot_bit(32'(digit_q), gi);
  end

  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NDIGIT - 1; i > 0; i--) begin
      zero_run    = zero_run && (din_shadow_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    nib_sel   = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < NDIGIT; i++) begin
      if (digit_q == DW'(i)) begin
        nib_sel   = din_shadow_q[4*i +: 4];
        dp_sel    = dp_shadow_q[i];
        blank_sel = lz_blank[i];
      end
    end
  end

  seg7_hex_decoder u_dec (
    .nibble_i (nib_sel),
    .glyph_o  (glyph)
  );

  assign an_on = (pwm_q <= w_bright);

  always_comb begin
    an_d = '0;
    sg_d = '0;
    dp_d = 1'b0;
    if (an_on) begin
      an_d = an_onehot;
      dp_d = dp_sel;
      if (!(w_blank_lz && blank_sel)) begin
        sg_d = glyph;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_q        <= '0;
      digit_q      <= '0;
      pwm_q        <= '0;
      din_shadow_q <= '0;
      dp_shadow_q  <= '0;
      frame_q      <= 1'b0;
      sg_q         <= SG_OFF;
      dp_q         <= POL;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      pwm_q        <= pwm_q + 1'b1;
      din_shadow_q <= din_shadow_d;
      dp_shadow_q  <= dp_shadow_d;
      frame_q      <= frame_d;
      sg_q         <= sg_d ^ SG_OFF;
      dp_q         <= dp_d ^ POL;
      an_q         <= an_d ^ AN_OFF;
    end
  end

  assign r_sg    = sg_q;
  assign r_dp    = dp_q;
  assign r_an    = an_q;
  assign r_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: a 4-digit active-low bank and a 1-digit active-high bank.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] din_a;
  logic [3:0]  dpin_a;
  logic        blz_a;
  logic [1:0]  bright_a;
  logic [6:0]  sg_a;
  logic        dp_a;
  logic [3:0]  an_a;
  logic        frame_a;

  logic [3:0]  din_b;
  logic [0:0]  dpin_b;
  logic        blz_b;
  logic [1:0]  bright_b;
  logic [6:0]  sg_b;
  logic        dp_b;
  logic [0:0]  an_b;
  logic        frame_b;

  seg7_scan_ctrl #(.NDIGIT(4), .DIV(4), .PWM_BITS(2), .ACTIVE_LOW(1)) dut_a (
    .w_clk(clk), .w_rst(rst), .w_din(din_a), .w_dp(dpin_a), .w_blank_lz(blz_a),
    .w_bright(bright_a), .r_sg(sg_a), .r_dp(dp_a), .r_an(an_a), .r_frame(frame_a)
  );

  seg7_scan_ctrl #(.NDIGIT(1), .DIV(4), .PWM_BITS(2), .ACTIVE_LOW(0)) dut_b (
    .w_clk(clk), .w_rst(rst), .w_din(din_b), .w_dp(dpin_b), .w_blank_lz(blz_b),
    .w_bright(bright_b), .r_sg(sg_b), .r_dp(dp_b), .r_an(an_b), .r_frame(frame_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0]     din;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][6:0] glyph;   // active-high expected glyph per digit, index = digit
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps until the chosen bank's frame pulse is seen; cycles = edges advanced.
  task automatic wait_frame(input bit sel_b, output int cycles);
    logic f;
    cycles = 0;
    do begin
      step(1);
      cycles++;
      f = sel_b ? frame_b : frame_a;
    end while (f !== 1'b1 && cycles < 64);
    check(sel_b ? "frame_b wait" : "frame_a wait", 16'(f), 16'd1);
  endtask

  initial begin
    int          cyc;
    int          on_cnt;
    logic [3:0]  exp_an;
    logic [6:0]  exp_sg;
    logic        exp_dp;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}};
    vecs[1] = '{16'h0050, 4'b0100, 1'b1, {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vecs[3] = '{16'h7B64, 4'b1001, 1'b0, {7'b1110000, 7'b0011111, 7'b1011111, 7'b0110011}};
    vecs[4] = '{16'h0D08, 4'b0000, 1'b1, {7'b0000000, 7'b0111101, 7'b1111110, 7'b1111111}};
    vecs[5] = '{16'hE3C9, 4'b0010, 1'b1, {7'b1001111, 7'b1111001, 7'b1001110, 7'b1111011}};

    rst = 1'b1;
    din_a = 16'h12AF; dpin_a = 4'b0; blz_a = 1'b0; bright_a = 2'd3;
    din_b = 4'h8;     dpin_b = 1'b0; blz_b = 1'b0; bright_b = 2'd3;
    step(2);
    check("reset an_a", 16'(an_a), 16'hF);
    check("reset sg_a", 16'(sg_a), 16'h7F);
    check("reset dp_a", 16'(dp_a), 16'd1);
    check("reset frame_a", 16'(frame_a), 16'd0);
    check("reset an_b", 16'(an_b), 16'd0);
    check("reset sg_b", 16'(sg_b), 16'h00);
    check("reset dp_b", 16'(dp_b), 16'd0);
    rst = 1'b0;

    // Whole-frame vectors: snapshot, then one sample at the start of each digit slot.
    for (int v = 0; v < 6; v++) begin
      din_a = vecs[v].din; dpin_a = vecs[v].dp; blz_a = vecs[v].blz;
      wait_frame(1'b0, cyc);
      step(1);
      for (int d = 0; d < 4; d++) begin
        exp_an = ~(4'b0001 << d);
        exp_sg = ~vecs[v].glyph[d];
        exp_dp = ~vecs[v].dp[d];
        check($sformatf("vec%0d d%0d an", v, d), 16'(an_a), 16'(exp_an));
        check($sformatf("vec%0d d%0d sg", v, d), 16'(sg_a), 16'(exp_sg));
        check($sformatf("vec%0d d%0d dp", v, d), 16'(dp_a), 16'(exp_dp));
        step(4);
      end
      $display("vec %0d: din=%h dp=%b blz=%0d checked", v, vecs[v].din, vecs[v].dp, vecs[v].blz);
    end

    // Frame pulse is one cycle wide and repeats every 16 cycles.
    wait_frame(1'b0, cyc);
    step(1);
    check("frame_a width", 16'(frame_a), 16'd0);
    wait_frame(1'b0, cyc);
    check("frame_a period", 16'(cyc + 1), 16'd16);
    $display("frame period: %0d cycles", cyc + 1);

    // Mid-frame update is held off until the next snapshot.
    din_a = 16'h1111; dpin_a = 4'b0; blz_a = 1'b0;
    wait_frame(1'b0, cyc);
    step(9);
    din_a = 16'h2222;
    exp_sg = ~7'b0110000;
    check("midframe d2 an", 16'(an_a), 16'hB);
    check("midframe d2 sg", 16'(sg_a), 16'(exp_sg));
    step(4);
    check("midframe d3 an", 16'(an_a), 16'h7);
    check("midframe d3 sg", 16'(sg_a), 16'(exp_sg));
    wait_frame(1'b0, cyc);
    step(1);
    exp_sg = ~7'b1101101;
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      check($sformatf("newframe d%0d an", d), 16'(an_a), 16'(exp_an));
      check($sformatf("newframe d%0d sg", d), 16'(sg_a), 16'(exp_sg));
      step(4);
    end
    $display("midframe update 1111->2222 checked");

    // Brightness: lit cycles per 4-cycle slot equal bright+1.
    din_a = 16'h8888; dpin_a = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      bright_a = 2'(b);
      wait_frame(1'b0, cyc);
      step(1);
      for (int d = 0; d < 4; d++) begin
        on_cnt = 0;
        exp_an = ~(4'b0001 << d);
        for (int j = 0; j < 4; j++) begin
          if (an_a != 4'hF) begin
            on_cnt++;
            check($sformatf("pwm b%0d d%0d an", b, d), 16'(an_a), 16'(exp_an));
          end else begin
            check($sformatf("pwm b%0d d%0d off sg", b, d), 16'(sg_a), 16'h7F);
            check($sformatf("pwm b%0d d%0d off dp", b, d), 16'(dp_a), 16'd1);
          end
          step(1);
        end
        check($sformatf("pwm b%0d d%0d on count", b, d), 16'(on_cnt), 16'(b + 1));
      end
      $display("brightness %0d checked", b);
    end
    bright_a = 2'd3;

    // Reset while digit 2 is active aborts the frame and clears the shadow.
    din_a = 16'h9999; dpin_a = 4'b1111; blz_a = 1'b0;
    wait_frame(1'b0, cyc);
    step(9);
    check("pre-reset an", 16'(an_a), 16'hB);
    rst = 1'b1;
    step(1);
    check("midreset an", 16'(an_a), 16'hF);
    check("midreset sg", 16'(sg_a), 16'h7F);
    check("midreset dp", 16'(dp_a), 16'd1);
    check("midreset frame", 16'(frame_a), 16'd0);
    rst = 1'b0;
    step(1);
    exp_sg = ~7'b1111110;
    check("post-reset d0 an", 16'(an_a), 16'hE);
    check("post-reset d0 sg", 16'(sg_a), 16'(exp_sg));
    check("post-reset d0 dp", 16'(dp_a), 16'd1);
    step(4);
    check("post-reset d1 an", 16'(an_a), 16'hD);
    check("post-reset d1 sg", 16'(sg_a), 16'(exp_sg));
    wait_frame(1'b0, cyc);
    check("post-reset first frame", 16'(cyc), 16'd11);
    step(1);
    exp_sg = ~7'b1111011;
    check("post-reset snapshot sg", 16'(sg_a), 16'(exp_sg));
    check("post-reset snapshot dp", 16'(dp_a), 16'd0);
    $display("mid-scan reset checked");

    // Single-digit active-high bank: every tick is a frame wrap.
    wait_frame(1'b1, cyc);
    wait_frame(1'b1, cyc);
    check("b frame period", 16'(cyc), 16'd4);
    for (int j = 0; j < 8; j++) begin
      step(1);
      check($sformatf("b cyc%0d an", j), 16'(an_b), 16'd1);
      check($sformatf("b cyc%0d sg", j), 16'(sg_b), 16'h7F);
      check($sformatf("b cyc%0d dp", j), 16'(dp_b), 16'd0);
    end
    $display("single-digit bank checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
